// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter: FSM state
// encoding, serial framing constants and the default bit period.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  localparam logic START_BIT             = 1'b0;
  localparam logic STOP_BIT              = 1'b1;
  localparam int   FRAME_BITS            = 10;  // start + 8 data + stop
  localparam int   DEFAULT_CLKS_PER_BIT  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 so that a reset never looks like a start bit.
// Ports:
//   clk      system clock, rising edge
//   bReset   synchronous active-low reset
//   i_async  raw asynchronous serial input
//   o_sync   synchronized line (2 clk delay)
// ---------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic bReset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!bReset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rcvr.sv
// ---------------------------------------------------------------------------
// uart_rcvr
// 8N1 serial receiver. Bit timing comes from a divider on clk; each bit is
// sampled at its centre. The received byte is held in RCV_datareg under a
// valid/ack handshake; overrun and framing errors are sticky.
// Ports:
//   clk          system clock, rising edge
//   bReset       synchronous active-low reset
//   Serial_in    asynchronous serial line, idle high
//   RCV_datareg  last good received byte
//   Byte_valid   RCV_datareg holds an uncollected byte
//   Byte_ack     one-cycle pulse, host has taken RCV_datareg
//   Err_clr      one-cycle pulse, clears sticky error flags
//   Overrun_err  sticky, a byte was dropped because Byte_valid was set
//   Frame_err    sticky, stop bit sampled 0
//   Busy         FSM is not in IDLE
//   o_dbg_state  current FSM state, for observation only
// ---------------------------------------------------------------------------
module uart_rcvr
  import uart_pkg::*;
#(
  parameter int WordSize     = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                clk,
  input  logic                bReset,
  input  logic                Serial_in,
  output logic [WordSize-1:0] RCV_datareg,
  output logic                Byte_valid,
  input  logic                Byte_ack,
  input  logic                Err_clr,
  output logic                Overrun_err,
  output logic                Frame_err,
  output logic                Busy,
  output uart_state_t         o_dbg_state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(WordSize + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WordSize - 1);

  logic                w_line;
  uart_state_t         r_state;
  logic [CNT_W-1:0]    r_clk_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [WordSize-1:0] r_shift;
  logic [WordSize-1:0] r_data;
  logic                r_valid;
  logic                r_ovr;
  logic                r_ferr;

  logic w_tick_full;
  logic w_stop_sample;
  logic w_deliver;
  logic w_bad_stop;

  uart_rx_sync u_sync (
    .clk     (clk),
    .bReset  (bReset),
    .i_async (Serial_in),
    .o_sync  (w_line)
  );

  always_comb begin
    w_tick_full   = (r_clk_cnt == BIT_LAST);
    w_stop_sample = (r_state == ST_STOP) && w_tick_full;
    w_deliver     = w_stop_sample && (w_line == STOP_BIT);
    w_bad_stop    = w_stop_sample && (w_line != STOP_BIT);
  end

  // Receive FSM. The clock counter measures half a bit in START (to land on
  // the start-bit centre) and whole bits afterwards (bit centres).
  always_ff @(posedge clk) begin
    if (!bReset) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_line == START_BIT) begin
            r_state   <= ST_START;
            r_clk_cnt <= '0;
          end
        end
        ST_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            // A line already back high at mid start bit is a glitch.
            r_state   <= (w_line == START_BIT) ? ST_DATA : ST_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick_full) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_line, r_shift[WordSize-1:1]};  // LSB arrives first
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == WORD_LAST) r_state <= ST_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tick_full) begin
            r_clk_cnt <= '0;
            r_state   <= w_deliver ? ST_IDLE : ST_BREAK;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          // Wait out a held-low line so it cannot re-trigger a start.
          if (w_line == STOP_BIT) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake: Byte_valid rises when a byte is loaded and stays high until
  // the host pulses Byte_ack. A delivery in the ack cycle replaces the byte
  // and keeps Byte_valid high; a delivery while valid and not acked drops the
  // new byte and flags an overrun. Error set beats Err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (!bReset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_deliver && (!r_valid || Byte_ack)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (Byte_ack) begin
        r_valid <= 1'b0;
      end

      if (Err_clr) begin
        r_ovr  <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (w_deliver && r_valid && !Byte_ack) r_ovr <= 1'b1;
      if (w_bad_stop) r_ferr <= 1'b1;
    end
  end

  assign RCV_datareg = r_data;
  assign Byte_valid  = r_valid;
  assign Overrun_err = r_ovr;
  assign Frame_err   = r_ferr;
  assign Busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rcvr.sv
// ---------------------------------------------------------------------------
// tb_uart_rcvr
// Directed scenarios followed by randomized frames, checked against a
// frame-level reference model (expected byte, delivery cycle, sticky flags).
// ---------------------------------------------------------------------------
module tb_uart_rcvr;
  import uart_pkg::*;

  localparam int C       = 8;
  // 2 synchronizer cycles + half bit to the start centre + 9 bit periods to
  // the stop centre + 1 cycle to register the byte.
  localparam int EXP_LAT = 2 + C / 2 + 9 * C + 1;

  logic        clk = 1'b0;
  logic        bReset;
  logic        Serial_in;
  logic [7:0]  RCV_datareg;
  logic        Byte_valid;
  logic        Byte_ack;
  logic        Err_clr;
  logic        Overrun_err;
  logic        Frame_err;
  logic        Busy;
  uart_state_t dbg_state;

  uart_rcvr #(.WordSize(8), .CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .bReset      (bReset),
    .Serial_in   (Serial_in),
    .RCV_datareg (RCV_datareg),
    .Byte_valid  (Byte_valid),
    .Byte_ack    (Byte_ack),
    .Err_clr     (Err_clr),
    .Overrun_err (Overrun_err),
    .Frame_err   (Frame_err),
    .Busy        (Busy),
    .o_dbg_state (dbg_state)
  );

  // ---- clock / cycle counter ----
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- monitor: record every Byte_valid rise (cycle, byte) ----
  int         rise_cyc_q[$];
  logic [7:0] rise_data_q[$];
  logic       prev_valid = 1'b0;

  always @(posedge clk) begin
    #2;
    if (Byte_valid && !prev_valid) begin
      rise_cyc_q.push_back(cyc);
      rise_data_q.push_back(RCV_datareg);
    end
    prev_valid = Byte_valid;
  end

  // ---- scoreboard ----
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---- driver tasks (all called at a negedge) ----
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    Byte_ack = 1'b1;
    @(negedge clk);
    Byte_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    Err_clr = 1'b1;
    @(negedge clk);
    Err_clr = 1'b0;
  endtask

  // Drives one 8N1 frame starting at the current negedge. If abort_at >= 0,
  // a one-cycle reset is applied at that cycle of the frame and the line is
  // released high (the transmitter is abandoned too).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int abort_at);
    logic [9:0] bits;
    bits = {stop_bit, b, START_BIT};
    for (int i = 0; i < 10 * C; i++) begin
      Serial_in = bits[i / C];
      if (i == abort_at) begin
        bReset = 1'b0;
        @(negedge clk);
        bReset    = 1'b1;
        Serial_in = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_rise(input string tag, input int n0, input logic [7:0] d, output int rc);
    int budget;
    budget = 200;
    rc = -1;
    while (rise_cyc_q.size() == 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (rise_cyc_q.size() == 0) begin
      check_eq({tag, "_seen"}, 32'd0, 32'd1);
    end else begin
      rc = rise_cyc_q.pop_front();
      check_eq({tag, "_lat"}, rc - n0, EXP_LAT);
      check_eq({tag, "_data"}, rise_data_q.pop_front(), d);
    end
  endtask

  task automatic wait_valid_and_ack();
    int budget;
    budget = 300;
    while (!Byte_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("b2b_ack_wait", {31'd0, Byte_valid}, 32'd1);
    pulse_ack();
  endtask

  // ---- main sequence ----
  int         n0, n1, rc0, rc1;
  logic       seen_busy, busy_drop;
  logic       m_valid, m_ovr, m_ferr, good;
  logic [7:0] m_data, b;

  initial begin
    bReset = 1'b0; Serial_in = 1'b1; Byte_ack = 1'b0; Err_clr = 1'b0;
    tick(3);
    bReset = 1'b1;
    tick(1);

    check_eq("rst_valid", {31'd0, Byte_valid}, 32'd0);
    check_eq("rst_data", {24'd0, RCV_datareg}, 32'd0);
    check_eq("rst_ovr", {31'd0, Overrun_err}, 32'd0);
    check_eq("rst_ferr", {31'd0, Frame_err}, 32'd0);
    check_eq("rst_busy", {31'd0, Busy}, 32'd0);

    // Single frame 0xA5
    n0 = cyc;
    send_frame(8'hA5, 1'b1, -1);
    expect_rise("a5", n0, 8'hA5, rc0);
    check_eq("a5_ferr", {31'd0, Frame_err}, 32'd0);
    check_eq("a5_ovr", {31'd0, Overrun_err}, 32'd0);
    pulse_ack();
    check_eq("a5_ack_valid", {31'd0, Byte_valid}, 32'd0);
    check_eq("a5_ack_data", {24'd0, RCV_datareg}, 32'hA5);

    // Back-to-back 0x00 then 0xFF, each acked
    fork
      begin
        n0 = cyc;
        send_frame(8'h00, 1'b1, -1);
        n1 = cyc;
        send_frame(8'hFF, 1'b1, -1);
      end
      begin
        wait_valid_and_ack();
        wait_valid_and_ack();
      end
    join
    expect_rise("b2b0", n0, 8'h00, rc0);
    expect_rise("b2b1", n1, 8'hFF, rc1);
    check_eq("b2b_spacing", rc1 - rc0, 10 * C);
    check_eq("b2b_ferr", {31'd0, Frame_err}, 32'd0);
    check_eq("b2b_ovr", {31'd0, Overrun_err}, 32'd0);
    tick(2);
    check_eq("b2b_valid", {31'd0, Byte_valid}, 32'd0);

    // 2-cycle glitch on an idle line
    seen_busy = 1'b0;
    Serial_in = 1'b0;
    tick(2);
    Serial_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      seen_busy |= Busy;
      tick(1);
    end
    tick(2 * C);
    check_eq("glitch_busy_pulse", {31'd0, seen_busy}, 32'd1);
    check_eq("glitch_idle", {31'd0, Busy}, 32'd0);
    check_eq("glitch_no_rise", rise_cyc_q.size(), 32'd0);
    check_eq("glitch_ferr", {31'd0, Frame_err}, 32'd0);
    check_eq("glitch_ovr", {31'd0, Overrun_err}, 32'd0);

    // Framing error 0x3C with stop=0, line held low, then 0x11
    send_frame(8'h3C, 1'b0, -1);
    busy_drop = 1'b0;
    for (int i = 0; i < 200; i++) begin
      busy_drop |= !Busy;
      tick(1);
    end
    Serial_in = 1'b1;
    tick(2 * C);
    check_eq("brk_ferr", {31'd0, Frame_err}, 32'd1);
    check_eq("brk_held", {31'd0, busy_drop}, 32'd0);
    check_eq("brk_exit", {31'd0, Busy}, 32'd0);
    check_eq("brk_no_rise", rise_cyc_q.size(), 32'd0);
    n0 = cyc;
    send_frame(8'h11, 1'b1, -1);
    expect_rise("after_brk", n0, 8'h11, rc0);
    pulse_clr();
    check_eq("errclr_ferr", {31'd0, Frame_err}, 32'd0);
    pulse_ack();

    // Overrun: 0x12 then 0x34 without ack
    n0 = cyc;
    send_frame(8'h12, 1'b1, -1);
    expect_rise("ovr_first", n0, 8'h12, rc0);
    send_frame(8'h34, 1'b1, -1);
    check_eq("ovr_data", {24'd0, RCV_datareg}, 32'h12);
    check_eq("ovr_valid", {31'd0, Byte_valid}, 32'd1);
    check_eq("ovr_flag", {31'd0, Overrun_err}, 32'd1);
    check_eq("ovr_no_rise", rise_cyc_q.size(), 32'd0);
    pulse_ack();
    pulse_clr();
    check_eq("ovr_clr", {31'd0, Overrun_err}, 32'd0);

    // Same again, with the ack landing on the delivery cycle
    n0 = cyc;
    send_frame(8'h12, 1'b1, -1);
    expect_rise("coin_first", n0, 8'h12, rc0);
    n0 = cyc;
    fork
      send_frame(8'h34, 1'b1, -1);
      begin
        while (cyc < n0 + EXP_LAT - 1) @(negedge clk);
        pulse_ack();
      end
    join
    check_eq("coin_data", {24'd0, RCV_datareg}, 32'h34);
    check_eq("coin_valid", {31'd0, Byte_valid}, 32'd1);
    check_eq("coin_ovr", {31'd0, Overrun_err}, 32'd0);
    pulse_ack();

    // Reset in the middle of DATA of 0x77
    send_frame(8'h77, 1'b1, 3 * C + 6);
    check_eq("mid_rst_data", {24'd0, RCV_datareg}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, Byte_valid}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, Busy}, 32'd0);
    tick(3 * C);
    check_eq("mid_rst_no_rise", rise_cyc_q.size(), 32'd0);
    n0 = cyc;
    send_frame(8'h88, 1'b1, -1);
    expect_rise("post_rst", n0, 8'h88, rc0);
    pulse_ack();

    // Randomized frames against the frame-level model
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_data = 8'h88;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1 && m_valid) begin
        pulse_ack();
        m_valid = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
      end
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 5) != 0);
      n0   = cyc;
      send_frame(b, good, -1);
      if (good) begin
        if (!m_valid) begin
          m_valid = 1'b1;
          m_data  = b;
          exp_q.push_back(b);
          exp_cyc_q.push_back(n0 + EXP_LAT);
        end else begin
          m_ovr = 1'b1;
        end
        tick($urandom_range(0, 3));
      end else begin
        m_ferr = 1'b1;
        tick($urandom_range(0, 40));
        Serial_in = 1'b1;
        tick(2 * C);
      end

      while (rise_cyc_q.size() > 0) begin
        if (exp_q.size() == 0) begin
          check_eq("rnd_unexpected_rise", rise_data_q.pop_front(), 32'hFFFF_FFFF);
          void'(rise_cyc_q.pop_front());
        end else begin
          check_eq("rnd_rise_data", rise_data_q.pop_front(), exp_q.pop_front());
          check_eq("rnd_rise_cyc", rise_cyc_q.pop_front(), exp_cyc_q.pop_front());
        end
      end
      check_eq("rnd_missing_rise", exp_q.size(), 32'd0);
      exp_q.delete();
      exp_cyc_q.delete();
      check_eq("rnd_valid", {31'd0, Byte_valid}, {31'd0, m_valid});
      check_eq("rnd_data", {24'd0, RCV_datareg}, {24'd0, m_data});
      check_eq("rnd_ovr", {31'd0, Overrun_err}, {31'd0, m_ovr});
      check_eq("rnd_ferr", {31'd0, Frame_err}, {31'd0, m_ferr});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---- watchdog ----
  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rcvr.md
Name: uart_rcvr

Overview:
- Serial receiver matching the system UART transmitter. Accepts an asynchronous 8N1 frame on Serial_in: start 0, 8 data bits LSB first, stop 1.
- Reassembles the byte and holds it in a data register under a valid/ack handshake until its bus wrapper collects it.
- Bit timing is derived from the system clock by an internal divider; no second clock exists.

Parameters:
- WordSize, 8, data bits per frame.
- CLKS_PER_BIT, 8, clk cycles per serial bit. Must be even and >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- bReset  input  1  synchronous active-low reset.
- Serial_in  input  1  asynchronous serial line, idle high.
- RCV_datareg  output  WordSize  last good received byte.
- Byte_valid  output  1  RCV_datareg holds an uncollected byte.
- Byte_ack  input  1  one-cycle pulse; host has taken RCV_datareg.
- Err_clr  input  1  one-cycle pulse; clears sticky error flags.
- Overrun_err  output  1  sticky; a byte was lost because Byte_valid was still set.
- Frame_err  output  1  sticky; stop bit was sampled 0.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock, synchronous, active-low. On bReset=0 at a rising edge, all outputs and state clear.
  - RCV_datareg=0, Byte_valid=0, Overrun_err=0, Frame_err=0, Busy=0.
  - State=IDLE, synchronizer flops=1, shift register=0, counters=0.
  - Reset mid-frame aborts the frame. No partial byte is ever delivered.
- Input synchronizer: 2 flops, reset to 1. "line" below means the synchronizer output.
- FSM states and transitions:
  - IDLE: when line=0, go to START and clear the clock counter.
  - START: on clock counter = CLKS_PER_BIT/2-1:
    - line=0: go to DATA, clear counters.
    - line=1: false start, go to IDLE with no flags.
  - DATA: every CLKS_PER_BIT cycles, sample line and shift it into the MSB of the shift register (right shift). After the WordSize-th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample line:
    - line=1: deliver the byte (see below), go to IDLE.
    - line=0: set Frame_err, discard the byte, go to BREAK.
  - BREAK: stay until line=1, then go to IDLE. A held-low line causes no re-trigger.
- Sample points: bit centres. If the falling edge is seen on the line in cycle t:
  - start sample at t+CLKS_PER_BIT/2;
  - data bit i at t+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT;
  - stop bit at t+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
- Latency: Byte_valid rises one cycle after the stop sample. With defaults this is 79 clk after the raw Serial_in falling edge (2 synchronizer cycles included).
- Delivery, when Byte_valid=0 or Byte_ack=1 in the same cycle: load RCV_datareg and set Byte_valid=1. Ack and delivery coinciding means the new byte wins, Byte_valid stays 1, and no overrun is flagged.
- Delivery, when Byte_valid=1 and Byte_ack=0: RCV_datareg is kept (old byte preserved), the new byte is dropped, and Overrun_err is set.
- Byte_ack while Byte_valid=0 is ignored. Byte_ack without a coinciding delivery clears Byte_valid on the next edge; RCV_datareg keeps its value.
- Error flags are sticky. Err_clr clears both. If a new error occurs in the same cycle as Err_clr, the set wins.
- Back-to-back frames with no idle gap are supported: IDLE detects the next start on the cycle after the stop sample.

Decomposition:
- Shared package uart_pkg, also used by the transmitter:
  - state encoding (IDLE, START, DATA, STOP, BREAK);
  - START_BIT=0, STOP_BIT=1, frame length constant 10;
  - default CLKS_PER_BIT.
- One sub-module: uart_rx_sync, the 2-flop synchronizer with reset value 1.
- The FSM, counters and shift register stay in uart_rcvr.

Test Plan:
- Frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1), CLKS_PER_BIT=8 -> Byte_valid rises 79 clk after the start edge, RCV_datareg=0xA5, no errors; Byte_ack -> Byte_valid=0 next cycle.
- Back-to-back 0x00 then 0xFF with no gap, acking each -> two deliveries of 0x00 and 0xFF, 80 clk apart, no errors.
- 2-clk low glitch on an idle line -> returns to IDLE, Busy pulses, no Byte_valid, no flags.
- Frame 0x3C with stop=0, line held low 200 clk, then frame 0x11 -> Frame_err=1, 0x3C not delivered, single BREAK, then 0x11 delivered; Err_clr -> Frame_err=0.
- Frames 0x12 then 0x34 without ack -> RCV_datareg=0x12, Overrun_err=1. Repeat with Byte_ack coinciding with the 0x34 delivery cycle -> RCV_datareg=0x34, Overrun_err=0.
- bReset=0 for 1 cycle in the middle of DATA of frame 0x77 -> outputs cleared; following frame 0x88 -> 0x88 delivered correctly, 0x77 never appears.
